// File: rtl/hamming_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hamming_mem_ctrl : Hamming(38,32) read/check/correct/write-back controller
//                    sharing one synchronous RAM port with a background scrubber
// Rev 1.0
// ----------------------------------------------------------------------------
module hamming_mem_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int SCRUB_MAX_WAIT = 64,
    parameter int WRITEBACK      = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [37:0]       rsp_data,
    output logic              rsp_corr,
    output logic              rsp_uncorr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [37:0]       mem_wdata,
    input  logic [37:0]       mem_rdata,
    input  logic              scrub_en,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int TMR_W  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam int WAIT_W = ($clog2(SCRUB_MAX_WAIT + 1) > 0) ? $clog2(SCRUB_MAX_WAIT + 1) : 1;

    localparam logic [TMR_W-1:0]  C_TMR_LAST  = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX  = WAIT_W'(SCRUB_MAX_WAIT);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  C_CNT_SAT   = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [5:0] f_syndrome(input logic [37:0] cw);
        logic [5:0] s;
        logic [5:0] pos;
        s = '0;
        for (int j = 1; j <= 38; j++) begin
            pos = 6'(j);
            for (int i = 0; i < 6; i++) begin
                if (pos[i]) begin
                    s[i] = s[i] ^ cw[j-1];
                end
            end
        end
        return s;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_live;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_src_scrub;
    logic [37:0]         r_word;
    logic                r_corr;
    logic                r_uncorr;
    logic [ADDR_W-1:0]   r_scrub_addr;
    logic [TMR_W-1:0]    r_timer;
    logic                r_pending;
    logic [WAIT_W-1:0]   r_wait;
    logic [37:0]         r_rsp_data;
    logic                r_rsp_corr;
    logic                r_rsp_uncorr;
    logic [CNT_W-1:0]    r_corr_cnt;
    logic [CNT_W-1:0]    r_uncorr_cnt;

    logic [5:0]          w_synd;
    logic [37:0]         w_fixed;
    logic                w_fix_corr;
    logic                w_fix_uncorr;
    logic                w_idle;
    logic                w_starve;
    logic                w_accept;
    logic                w_launch;
    logic                w_rsp_load;
    logic                w_wait_inc;

    always_comb begin
        w_synd       = f_syndrome(mem_rdata);
        w_fix_corr   = (w_synd != 6'd0) && (w_synd <= 6'd38);
        w_fix_uncorr = (w_synd > 6'd38);
        w_fixed      = mem_rdata;
        if (w_fix_corr) begin
            w_fixed[w_synd - 6'd1] = ~mem_rdata[w_synd - 6'd1];
        end
    end

    // r_live keeps req_ready low for the first cycle out of reset.
    assign w_idle     = (r_state == S_IDLE);
    assign w_starve   = scrub_en && r_pending && (r_wait >= C_WAIT_MAX);
    assign req_ready  = rst_n && r_live && w_idle && !w_starve;
    assign w_accept   = req_valid && req_ready;
    assign w_launch   = rst_n && r_live && w_idle && !w_accept && r_pending && scrub_en;
    assign w_wait_inc = r_pending && (w_accept || (!w_idle && !r_src_scrub)) &&
                        (r_wait < C_WAIT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept || w_launch) w_state_nxt = S_RD;
            S_RD:    w_state_nxt = S_CHK;
            S_CHK:   w_state_nxt = (w_fix_corr && (WRITEBACK != 0)) ? S_WB : S_DONE;
            S_WB:    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory strobes are gated by rst_n so a reset landing in WB suppresses the write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        if (rst_n && (r_state == S_RD || r_state == S_WB)) begin
            mem_en   = 1'b1;
            mem_addr = r_addr;
        end
        if (rst_n && r_state == S_WB) begin
            mem_we    = 1'b1;
            mem_wdata = r_word;
        end
        if (r_state == S_DONE && !r_src_scrub) begin
            rsp_valid = 1'b1;
        end
    end

    assign w_rsp_load = !r_src_scrub &&
                        ((r_state == S_CHK && w_state_nxt == S_DONE) || r_state == S_WB);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_live       <= 1'b0;
            r_addr       <= '0;
            r_src_scrub  <= 1'b0;
            r_word       <= '0;
            r_corr       <= 1'b0;
            r_uncorr     <= 1'b0;
            r_scrub_addr <= '0;
            r_rsp_data   <= '0;
            r_rsp_corr   <= 1'b0;
            r_rsp_uncorr <= 1'b0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= req_addr;
                        r_src_scrub <= 1'b0;
                    end else if (w_launch) begin
                        r_addr      <= r_scrub_addr;
                        r_src_scrub <= 1'b1;
                    end
                end
                S_CHK: begin
                    r_word   <= w_fixed;
                    r_corr   <= w_fix_corr;
                    r_uncorr <= w_fix_uncorr;
                end
                S_DONE: begin
                    if (r_src_scrub) begin
                        r_scrub_addr <= (r_scrub_addr == C_ADDR_LAST) ? '0
                                                                      : r_scrub_addr + 1'b1;
                    end
                    if (r_corr && r_corr_cnt != C_CNT_SAT) begin
                        r_corr_cnt <= r_corr_cnt + 1'b1;
                    end
                    if (r_uncorr && r_uncorr_cnt != C_CNT_SAT) begin
                        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_rsp_load) begin
                r_rsp_data   <= (r_state == S_WB) ? r_word   : w_fixed;
                r_rsp_corr   <= (r_state == S_WB) ? r_corr   : w_fix_corr;
                r_rsp_uncorr <= (r_state == S_WB) ? r_uncorr : w_fix_uncorr;
            end
        end
    end

    // A timer hit wins over a same-cycle launch so no interval is lost.
    always_ff @(posedge clk) begin
        if (!rst_n || !scrub_en) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_wait    <= '0;
        end else begin
            if (r_timer == C_TMR_LAST) begin
                r_timer   <= '0;
                r_pending <= 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (w_launch) begin
                    r_pending <= 1'b0;
                end
            end
            if (w_launch) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign rsp_data   = r_rsp_data;
    assign rsp_corr   = r_rsp_corr;
    assign rsp_uncorr = r_rsp_uncorr;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hamming_mem_ctrl : directed vectors for CPU reads, scrubbing, starvation, reset
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hamming_mem_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters, CPU-only traffic.
    logic        a_rst_n, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_corr, a_rsp_uncorr;
    logic [7:0]  a_req_addr, a_mem_addr;
    logic [37:0] a_rsp_data, a_mem_wdata, a_mem_rdata;
    logic        a_mem_en, a_mem_we, a_scrub_en;
    logic [15:0] a_corr_cnt, a_uncorr_cnt;

    // Instance B: small memory, fast scrub, short starvation limit.
    logic        b_rst_n, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_corr, b_rsp_uncorr;
    logic [1:0]  b_req_addr, b_mem_addr;
    logic [37:0] b_rsp_data, b_mem_wdata, b_mem_rdata;
    logic        b_mem_en, b_mem_we, b_scrub_en;
    logic [15:0] b_corr_cnt, b_uncorr_cnt;

    hamming_mem_ctrl u_a (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_addr(a_req_addr),
        .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .rsp_corr(a_rsp_corr), .rsp_uncorr(a_rsp_uncorr), .mem_en(a_mem_en),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .scrub_en(a_scrub_en), .corr_cnt(a_corr_cnt),
        .uncorr_cnt(a_uncorr_cnt)
    );

    hamming_mem_ctrl #(
        .ADDR_W(2), .DEPTH(4), .SCRUB_INTERVAL(8), .SCRUB_MAX_WAIT(4),
        .WRITEBACK(1), .CNT_W(16)
    ) u_b (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .rsp_corr(b_rsp_corr), .rsp_uncorr(b_rsp_uncorr), .mem_en(b_mem_en),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .scrub_en(b_scrub_en), .corr_cnt(b_corr_cnt),
        .uncorr_cnt(b_uncorr_cnt)
    );

    // Synchronous RAM models with a backdoor load port.
    logic [37:0] mem_a [256];
    logic [37:0] mem_b [4];
    logic        a_bd_we, b_bd_we;
    logic [7:0]  a_bd_addr;
    logic [1:0]  b_bd_addr;
    logic [37:0] a_bd_data, b_bd_data;

    always @(posedge clk) begin
        if (a_bd_we) mem_a[a_bd_addr] <= a_bd_data;
        else if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
            else          a_mem_rdata <= mem_a[a_mem_addr];
        end
        if (b_bd_we) mem_b[b_bd_addr] <= b_bd_data;
        else if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
            else          b_mem_rdata <= mem_b[b_mem_addr];
        end
    end

    // Access log of instance B.
    logic        log_we [$];
    logic [1:0]  log_ad [$];
    logic [37:0] log_wd [$];
    int          b_rd_cnt  = 0;
    int          b_rsp_cnt = 0;
    always @(negedge clk) begin
        if (b_mem_en) begin
            log_we.push_back(b_mem_we);
            log_ad.push_back(b_mem_addr);
            log_wd.push_back(b_mem_wdata);
            if (!b_mem_we) b_rd_cnt++;
        end
        if (b_rsp_valid) b_rsp_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke_a(input logic [7:0] ad, input logic [37:0] d);
        @(negedge clk);
        a_bd_we = 1'b1; a_bd_addr = ad; a_bd_data = d;
        @(negedge clk);
        a_bd_we = 1'b0;
    endtask

    task automatic poke_b(input logic [1:0] ad, input logic [37:0] d);
        @(negedge clk);
        b_bd_we = 1'b1; b_bd_addr = ad; b_bd_data = d;
        @(negedge clk);
        b_bd_we = 1'b0;
    endtask

    int          t_lat, t_nresp, t_wb_k;
    logic [37:0] t_data, t_wb_data;
    logic        t_corr, t_unc, t_wb;
    logic [7:0]  t_wb_addr;

    // Issue one CPU read on A; cycle k is the k-th cycle after the accepting edge.
    task automatic cpu_read_a(input logic [7:0] ad);
        int g = 0;
        t_lat = 0; t_nresp = 0; t_wb = 1'b0; t_wb_k = 0;
        t_data = '0; t_corr = 1'b0; t_unc = 1'b0; t_wb_addr = '0; t_wb_data = '0;
        @(negedge clk);
        while (!a_req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("rd_ready_wait", 64'(g < 20), 64'd1);
        a_req_valid = 1'b1;
        a_req_addr  = ad;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (a_rsp_valid) begin
                t_nresp++;
                if (t_lat == 0) begin
                    t_lat = k; t_data = a_rsp_data; t_corr = a_rsp_corr; t_unc = a_rsp_uncorr;
                end
            end
            if (a_mem_en && a_mem_we) begin
                t_wb = 1'b1; t_wb_k = k; t_wb_addr = a_mem_addr; t_wb_data = a_mem_wdata;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        preload;
        logic [37:0] word;
        logic [37:0] exp_data;
        logic        exp_corr;
        logic        exp_uncorr;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [9];
        int   m_corr = 0;
        int   m_unc  = 0;
        int   g;
        int   cpu_before;
        logic prev_rsp;
        logic found;
        logic        ex_we [6];
        logic [1:0]  ex_ad [6];

        vt[0] = '{8'd3,  1'b1, 38'h0,          38'h0,          1'b0, 1'b0};
        vt[1] = '{8'd7,  1'b1, 38'h10,         38'h0,          1'b1, 1'b0};
        vt[2] = '{8'd7,  1'b0, 38'h0,          38'h0,          1'b0, 1'b0};
        vt[3] = '{8'd9,  1'b1, 38'h0080000040, 38'h0080000040, 1'b0, 1'b1};
        vt[4] = '{8'd10, 1'b1, 38'h7,          38'h7,          1'b0, 1'b0};
        vt[5] = '{8'd11, 1'b1, 38'h2000000007, 38'h7,          1'b1, 1'b0};
        vt[6] = '{8'd12, 1'b1, 38'h18,         38'h19,         1'b1, 1'b0};
        vt[7] = '{8'd13, 1'b1, 38'h2000000001, 38'h2000000001, 1'b0, 1'b1};
        vt[8] = '{8'd14, 1'b1, 38'h3,          38'h7,          1'b1, 1'b0};
        ex_we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ex_ad = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};

        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_addr = '0; a_scrub_en = 1'b0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_addr = '0; b_scrub_en = 1'b0;
        a_bd_we = 1'b0; a_bd_addr = '0; a_bd_data = '0;
        b_bd_we = 1'b0; b_bd_addr = '0; b_bd_data = '0;

        poke_b(2'd0, 38'h0);
        poke_b(2'd1, 38'h0);
        poke_b(2'd2, 38'h10);
        poke_b(2'd3, 38'h0);
        @(negedge clk);
        check("rst_a_ready",  64'(a_req_ready), 64'd0);
        check("rst_a_rsp",    64'(a_rsp_valid), 64'd0);
        check("rst_a_data",   64'(a_rsp_data), 64'd0);
        check("rst_a_mem_en", 64'(a_mem_en), 64'd0);
        check("rst_a_cnt",    64'({a_corr_cnt, a_uncorr_cnt}), 64'd0);
        check("rst_b_mem_en", 64'(b_mem_en), 64'd0);
        check("rst_b_ready",  64'(b_req_ready), 64'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Table-driven CPU reads on instance A.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].preload) poke_a(vt[i].addr, vt[i].word);
            cpu_read_a(vt[i].addr);
            if (vt[i].exp_corr)   m_corr++;
            if (vt[i].exp_uncorr) m_unc++;
            check($sformatf("v%0d_latency", i), 64'(t_lat), vt[i].exp_corr ? 64'd4 : 64'd3);
            check($sformatf("v%0d_nresp", i),   64'(t_nresp), 64'd1);
            check($sformatf("v%0d_data", i),    64'(t_data), 64'(vt[i].exp_data));
            check($sformatf("v%0d_corr", i),    64'(t_corr), 64'(vt[i].exp_corr));
            check($sformatf("v%0d_uncorr", i),  64'(t_unc), 64'(vt[i].exp_uncorr));
            check($sformatf("v%0d_wb", i),      64'(t_wb), 64'(vt[i].exp_corr));
            if (vt[i].exp_corr) begin
                check($sformatf("v%0d_wb_cycle", i), 64'(t_wb_k), 64'd3);
                check($sformatf("v%0d_wb_addr", i),  64'(t_wb_addr), 64'(vt[i].addr));
                check($sformatf("v%0d_wb_data", i),  64'(t_wb_data), 64'(vt[i].exp_data));
            end
            check($sformatf("v%0d_corr_cnt", i),   64'(a_corr_cnt), 64'(m_corr));
            check($sformatf("v%0d_uncorr_cnt", i), 64'(a_uncorr_cnt), 64'(m_unc));
            check($sformatf("v%0d_hold", i),       64'(a_rsp_data), 64'(vt[i].exp_data));
        end

        // Reset landing in the write-back cycle.
        poke_a(8'd20, 38'h10);
        @(negedge clk);
        g = 0;
        while (!a_req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        a_req_valid = 1'b1;
        a_req_addr  = 8'd20;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("s6_in_wb", 64'(a_mem_we), 64'd1);
        a_rst_n = 1'b0;
        #1;
        check("s6_we_gated", 64'(a_mem_we), 64'd0);
        check("s6_en_gated", 64'(a_mem_en), 64'd0);
        @(negedge clk);
        check("s6_ready", 64'(a_req_ready), 64'd0);
        check("s6_rsp",   64'({a_rsp_valid, a_rsp_corr, a_rsp_uncorr}), 64'd0);
        check("s6_data",  64'(a_rsp_data), 64'd0);
        check("s6_mem",   64'({a_mem_en, a_mem_we, a_mem_addr}), 64'd0);
        check("s6_wdata", 64'(a_mem_wdata), 64'd0);
        check("s6_cnt",   64'({a_corr_cnt, a_uncorr_cnt}), 64'd0);
        check("s6_no_write", 64'(mem_a[20]), 64'h10);
        a_rst_n = 1'b1;
        cpu_read_a(8'd3);
        check("s6_re_latency", 64'(t_lat), 64'd3);
        check("s6_re_data",    64'(t_data), 64'd0);
        check("s6_re_flags",   64'({t_corr, t_unc, t_wb}), 64'd0);
        check("s6_re_cnt",     64'(a_corr_cnt), 64'd0);

        // Background scrub walk on instance B.
        @(negedge clk);
        b_scrub_en = 1'b1;
        g = 0;
        while (b_rd_cnt < 5 && g < 300) begin
            @(negedge clk);
            #1;
            g++;
        end
        b_scrub_en = 1'b0;
        check("s4_reads_seen", 64'(g < 300), 64'd1);
        repeat (8) @(negedge clk);
        check("s4_log_len", 64'(log_we.size()), 64'd6);
        if (log_we.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("s4_we%0d", i),   64'(log_we[i]), 64'(ex_we[i]));
                check($sformatf("s4_addr%0d", i), 64'(log_ad[i]), 64'(ex_ad[i]));
            end
            check("s4_wb_data", 64'(log_wd[3]), 64'd0);
        end
        check("s4_no_rsp",   64'(b_rsp_cnt), 64'd0);
        check("s4_corr_cnt", 64'(b_corr_cnt), 64'd1);
        check("s4_unc_cnt",  64'(b_uncorr_cnt), 64'd0);
        check("s4_repaired", 64'(mem_b[2]), 64'd0);

        // Starvation: CPU traffic held high while a scrub is pending.
        @(negedge clk);
        b_req_addr  = 2'd3;
        b_req_valid = 1'b1;
        b_scrub_en  = 1'b1;
        prev_rsp = 1'b0;
        found = 1'b0;
        cpu_before = 0;
        g = 0;
        while (!found && g < 150) begin
            @(negedge clk);
            g++;
            if (prev_rsp && !b_req_ready) found = 1'b1;
            else begin
                prev_rsp = b_rsp_valid;
                if (b_rsp_valid) cpu_before++;
            end
        end
        check("s5_starve_seen", 64'(found), 64'd1);
        check("s5_cpu_first",   64'(cpu_before >= 1), 64'd1);
        @(negedge clk);
        check("s5_scrub_rd",   64'({b_mem_en, b_mem_we}), 64'b10);
        check("s5_scrub_addr", 64'(b_mem_addr), 64'd1);
        @(negedge clk);
        check("s5_chk_no_rsp", 64'(b_rsp_valid), 64'd0);
        @(negedge clk);
        check("s5_done_no_rsp", 64'(b_rsp_valid), 64'd0);
        @(negedge clk);
        check("s5_ready_back", 64'(b_req_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("s5_cpu_resume", 64'(b_rsp_valid), 64'd1);
        check("s5_cpu_data",   64'(b_rsp_data), 64'd0);
        b_req_valid = 1'b0;
        b_scrub_en  = 1'b0;
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
